// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - BHT/PHT write scheduler: init sweep, update queue, read-modify-write FSM
module bp_update_sched #(
  parameter int BHT_DEPTH  = 10,
  parameter int PHT_DEPTH  = 6,
  parameter int IDX_LO     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          branchM,
  input  logic                          actual_takeM,
  input  logic [31:0]                   pcM,
  input  logic                          lookup_req,
  output logic                          bht_en,
  output logic                          bht_we,
  output logic [BHT_DEPTH-1:0]          bht_addr,
  output logic [PHT_DEPTH-1:0]          bht_wdata,
  input  logic [PHT_DEPTH-1:0]          bht_rdata,
  output logic                          pht_en,
  output logic                          pht_we,
  output logic [PHT_DEPTH-1:0]          pht_addr,
  output logic [1:0]                    pht_wdata,
  input  logic [1:0]                    pht_rdata,
  output logic                          init_done,
  output logic                          upd_drop,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  localparam int QW = $clog2(FIFO_DEPTH);
  localparam int EW = BHT_DEPTH + 1;
  localparam logic [QW-1:0] PTR_ONE = 1;
  localparam logic [QW:0]   CNT_ONE = 1;
  localparam logic [QW:0]   CNT_FULL = FIFO_DEPTH[QW:0];

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_HCAP,
    S_HWR,
    S_CCAP,
    S_CWR
  } state_t;

  state_t               state_q;
  logic [BHT_DEPTH-1:0] sweep_q;
  logic [BHT_DEPTH-1:0] idx_q;
  logic                 tk_q;
  logic [PHT_DEPTH-1:0] hist_q;
  logic [1:0]           ctr_q;
  logic                 init_done_q;

  logic [EW-1:0]        fifo_q [FIFO_DEPTH];
  logic [QW-1:0]        wr_ptr_q;
  logic [QW-1:0]        rd_ptr_q;
  logic [QW:0]          count_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;
  logic                 sweep_in_pht;
  logic                 unused_pc;

  // PC bits outside the index field do not select a BHT entry
  assign unused_pc = ^{pcM[31:IDX_LO+BHT_DEPTH], pcM[IDX_LO-1:0]};

  assign entry      = {pcM[IDX_LO+BHT_DEPTH-1:IDX_LO], actual_takeM};
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  // Pop only when issuing a BHT read; a push into a full queue survives if a pop frees a slot
  assign pop  = !rst && (state_q == S_IDLE) && !fifo_empty && !lookup_req;
  assign push = !rst && branchM && (state_q != S_INIT) && (!fifo_full || pop);
  assign upd_drop = !rst && branchM && !push;

  assign init_done = init_done_q;
  assign q_count   = count_q;

  // The PHT is smaller than the BHT, so only the first 2^PHT_DEPTH sweep steps touch it
  assign sweep_in_pht = ((sweep_q >> PHT_DEPTH) == '0);

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
    logic [1:0] n;
    case (c)
      2'b00:   n = t ? 2'b01 : 2'b00;
      2'b01:   n = t ? 2'b11 : 2'b00;
      2'b11:   n = t ? 2'b10 : 2'b01;
      default: n = t ? 2'b10 : 2'b11;
    endcase
    return n;
  endfunction

  // Queue storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= entry;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sweep and read-modify-write sequencing; lookup_req stalls the two write states
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
      tk_q        <= 1'b0;
      hist_q      <= '0;
      ctr_q       <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == '1) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (pop) begin
            idx_q   <= head[EW-1:1];
            tk_q    <= head[0];
            state_q <= S_HCAP;
          end
        end
        S_HCAP: begin
          hist_q  <= bht_rdata;
          state_q <= S_HWR;
        end
        S_HWR: begin
          if (!lookup_req) state_q <= S_CCAP;
        end
        S_CCAP: begin
          ctr_q   <= pht_rdata;
          state_q <= S_CWR;
        end
        S_CWR: begin
          if (!lookup_req) state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Table port drive; the RAMs sample these on the same edge that advances the FSM
  always_comb begin
    bht_en    = 1'b0;
    bht_we    = 1'b0;
    bht_addr  = '0;
    bht_wdata = '0;
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    if (!rst) begin
      case (state_q)
        S_INIT: begin
          bht_en   = 1'b1;
          bht_we   = 1'b1;
          bht_addr = sweep_q;
          if (sweep_in_pht) begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pht_addr  = sweep_q[PHT_DEPTH-1:0];
            pht_wdata = 2'b11;
          end
        end
        S_IDLE: begin
          if (pop) begin
            bht_en   = 1'b1;
            bht_addr = head[EW-1:1];
          end
        end
        S_HWR: begin
          if (!lookup_req) begin
            bht_en    = 1'b1;
            bht_we    = 1'b1;
            bht_addr  = idx_q;
            bht_wdata = {hist_q[PHT_DEPTH-2:0], tk_q};
            pht_en    = 1'b1;
            pht_addr  = hist_q;
          end
        end
        S_CWR: begin
          if (!lookup_req) begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pht_addr  = hist_q;
            pht_wdata = next_ctr(ctr_q, tk_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - directed bench for bp_update_sched with behavioural BHT/PHT RAMs
module tb_bp_update_sched;

  logic        clk;
  logic        rst;
  logic        branchM;
  logic        actual_takeM;
  logic [31:0] pcM;
  logic        lookup_req;
  logic        bht_en, bht_we;
  logic [9:0]  bht_addr;
  logic [5:0]  bht_wdata;
  logic [5:0]  bht_rdata;
  logic        pht_en, pht_we;
  logic [5:0]  pht_addr;
  logic [1:0]  pht_wdata;
  logic [1:0]  pht_rdata;
  logic        init_done;
  logic        upd_drop;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  logic [5:0] bht_mem [1024];
  logic [1:0] pht_mem [64];

  logic [9:0] bwa_q [$];
  logic [5:0] bwd_q [$];
  logic [5:0] pwa_q [$];
  logic [1:0] pwd_q [$];
  int         pwc_q [$];

  wire [17:0] bht_port = {bht_en, bht_we, bht_addr, bht_wdata};
  wire [9:0]  pht_rd   = {pht_en, pht_we, pht_addr, 2'b00};
  wire [9:0]  pht_port = {pht_en, pht_we, pht_addr, pht_wdata};
  wire [3:0]  en_all   = {bht_en, bht_we, pht_en, pht_we};

  bp_update_sched dut (
    .clk(clk), .rst(rst), .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM),
    .lookup_req(lookup_req),
    .bht_en(bht_en), .bht_we(bht_we), .bht_addr(bht_addr), .bht_wdata(bht_wdata), .bht_rdata(bht_rdata),
    .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr), .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
    .init_done(init_done), .upd_drop(upd_drop), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bht_en) begin
      if (bht_we) bht_mem[bht_addr] <= bht_wdata;
      else        bht_rdata <= bht_mem[bht_addr];
    end
    if (pht_en) begin
      if (pht_we) pht_mem[pht_addr] <= pht_wdata;
      else        pht_rdata <= pht_mem[pht_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int first, input int n);
    bwa_q.delete(); bwd_q.delete(); pwa_q.delete(); pwd_q.delete(); pwc_q.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      if (bht_en && bht_we) begin bwa_q.push_back(bht_addr); bwd_q.push_back(bht_wdata); end
      if (pht_en && pht_we) begin pwa_q.push_back(pht_addr); pwd_q.push_back(pht_wdata); pwc_q.push_back(first + i); end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; branchM = 1'b1; pcM = 32'h10; actual_takeM = 1'b1; #1;
    checks++; if (en_all !== 4'b0) begin errors++; $display("FAIL reset_en got %b want 0000", en_all); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
    checks++; if (upd_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", upd_drop); end
    tick();
    #1;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d want 0", q_count); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done2 got %b want 0", init_done); end
    tick();
  endtask

  task automatic test_init();
    rst = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      branchM = (k == 10); lookup_req = (k == 20); #1;
      checks++;
      if (bht_port !== {2'b11, k[9:0], 6'd0}) begin
        errors++; $display("FAIL init_bht k=%0d got %h want %h", k, bht_port, {2'b11, k[9:0], 6'd0});
      end
      checks++;
      if (k < 64) begin
        if (pht_port !== {2'b11, k[5:0], 2'b11}) begin
          errors++; $display("FAIL init_pht k=%0d got %h want %h", k, pht_port, {2'b11, k[5:0], 2'b11});
        end
      end else if ({pht_en, pht_we} !== 2'b00) begin
        errors++; $display("FAIL init_pht_off k=%0d got %b want 00", k, {pht_en, pht_we});
      end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early k=%0d got 1 want 0", k); end
      if (k == 10) begin
        checks++; if (upd_drop !== 1'b1) begin errors++; $display("FAIL init_drop got %b want 1", upd_drop); end
      end
      if (k == 11) begin
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL init_q_count got %0d want 0", q_count); end
      end
      tick();
    end
    branchM = 1'b0; lookup_req = 1'b0; #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", init_done); end
    checks++; if (en_all !== 4'b0) begin errors++; $display("FAIL idle_en got %b want 0000", en_all); end
    checks++; if (pht_mem[63] !== 2'b11 || bht_mem[1023] !== 6'd0) begin
      errors++; $display("FAIL init_mem got %b/%h want 11/00", pht_mem[63], bht_mem[1023]);
    end
    tick();
  endtask

  task automatic test_single_update();
    branchM = 1'b1; pcM = 32'h0000_0010; actual_takeM = 1'b1; #1;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL single_q0 got %0d want 0", q_count); end
    tick();
    branchM = 1'b0; #1;
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL single_q1 got %0d want 1", q_count); end
    checks++; if (bht_port !== {2'b10, 10'd4, 6'd0}) begin errors++; $display("FAIL single_bht_rd got %h want %h", bht_port, {2'b10, 10'd4, 6'd0}); end
    tick(); #1;
    checks++; if (en_all !== 4'b0) begin errors++; $display("FAIL single_hcap got %b want 0000", en_all); end
    tick(); #1;
    checks++; if (bht_port !== {2'b11, 10'd4, 6'b000001}) begin errors++; $display("FAIL single_bht_wr got %h want %h", bht_port, {2'b11, 10'd4, 6'b000001}); end
    checks++; if (pht_rd !== {2'b10, 6'd0, 2'b00}) begin errors++; $display("FAIL single_pht_rd got %h want %h", pht_rd, {2'b10, 6'd0, 2'b00}); end
    tick(); #1;
    checks++; if (en_all !== 4'b0) begin errors++; $display("FAIL single_ccap got %b want 0000", en_all); end
    tick(); #1;
    checks++; if (pht_port !== {2'b11, 6'd0, 2'b10}) begin errors++; $display("FAIL single_pht_wr got %h want %h", pht_port, {2'b11, 6'd0, 2'b10}); end
    tick(); #1;
    checks++; if (bht_mem[4] !== 6'd1 || pht_mem[0] !== 2'b10) begin
      errors++; $display("FAIL single_mem got %h/%b want 01/10", bht_mem[4], pht_mem[0]);
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL single_q_end got %0d want 0", q_count); end
    tick();
  endtask

  task automatic test_nt_walk();
    for (int i = 0; i < 3; i++) begin
      branchM = 1'b1; pcM = 32'h0000_0020; actual_takeM = 1'b0; tick();
    end
    branchM = 1'b0;
    collect(3, 20);
    checks++; if (pwa_q.size() !== 3 || bwa_q.size() !== 3) begin
      errors++; $display("FAIL nt_count got pht %0d bht %0d want 3 3", pwa_q.size(), bwa_q.size());
    end else begin
      checks++; if ({pwd_q[0], pwd_q[1], pwd_q[2]} !== 6'b11_01_00) begin
        errors++; $display("FAIL nt_walk got %b want 110100", {pwd_q[0], pwd_q[1], pwd_q[2]});
      end
      checks++; if ({pwc_q[0], pwc_q[1], pwc_q[2]} !== {32'd5, 32'd10, 32'd15}) begin
        errors++; $display("FAIL nt_cycles got %0d %0d %0d want 5 10 15", pwc_q[0], pwc_q[1], pwc_q[2]);
      end
      checks++; if ({bwa_q[2], bwd_q[2], pwa_q[2]} !== {10'd8, 6'd0, 6'd0}) begin
        errors++; $display("FAIL nt_addr got %h want %h", {bwa_q[2], bwd_q[2], pwa_q[2]}, {10'd8, 6'd0, 6'd0});
      end
    end
  endtask

  task automatic test_lookup_stall();
    branchM = 1'b1; pcM = 32'h0000_0010; actual_takeM = 1'b1; tick();
    branchM = 1'b0; #1;
    checks++; if (bht_port !== {2'b10, 10'd4, 6'd0}) begin errors++; $display("FAIL stall_bht_rd got %h want %h", bht_port, {2'b10, 10'd4, 6'd0}); end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      lookup_req = 1'b1; #1;
      checks++; if (en_all !== 4'b0) begin errors++; $display("FAIL stall_hwr%0d got %b want 0000", i, en_all); end
      tick();
    end
    checks++; if (bht_mem[4] !== 6'd1) begin errors++; $display("FAIL stall_unchanged got %h want 01", bht_mem[4]); end
    lookup_req = 1'b0; #1;
    checks++; if (bht_port !== {2'b11, 10'd4, 6'b000011}) begin errors++; $display("FAIL stall_bht_wr got %h want %h", bht_port, {2'b11, 10'd4, 6'b000011}); end
    checks++; if (pht_rd !== {2'b10, 6'd1, 2'b00}) begin errors++; $display("FAIL stall_pht_rd got %h want %h", pht_rd, {2'b10, 6'd1, 2'b00}); end
    tick(); tick(); #1;
    checks++; if (pht_port !== {2'b11, 6'd1, 2'b10}) begin errors++; $display("FAIL stall_pht_wr got %h want %h", pht_port, {2'b11, 6'd1, 2'b10}); end
    tick(); #1;
    checks++; if (bht_mem[4] !== 6'd3 || pht_mem[1] !== 2'b10) begin
      errors++; $display("FAIL stall_mem got %h/%b want 03/10", bht_mem[4], pht_mem[1]);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [5:0] tks;
    tks = 6'b11_1101;
    for (int i = 0; i < 6; i++) begin
      lookup_req = 1'b1; branchM = 1'b1; pcM = 32'((16 + i) * 4); actual_takeM = tks[i]; #1;
      checks++; if (q_count !== ((i < 4) ? 3'(i) : 3'd4)) begin errors++; $display("FAIL full_q%0d got %0d want %0d", i, q_count, (i < 4) ? i : 4); end
      checks++; if (upd_drop !== (i >= 4)) begin errors++; $display("FAIL full_drop%0d got %b want %b", i, upd_drop, i >= 4); end
      tick();
    end
    lookup_req = 1'b0; branchM = 1'b1; pcM = 32'(22 * 4); actual_takeM = 1'b0; #1;
    checks++; if (upd_drop !== 1'b0) begin errors++; $display("FAIL full_pushpop_drop got %b want 0", upd_drop); end
    checks++; if (bht_port !== {2'b10, 10'd16, 6'd0}) begin errors++; $display("FAIL full_pop_rd got %h want %h", bht_port, {2'b10, 10'd16, 6'd0}); end
    tick();
    branchM = 1'b0; #1;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_q got %0d want 4", q_count); end
    tick();
    collect(8, 40);
    checks++; if (bwa_q.size() !== 5 || pwa_q.size() !== 5) begin
      errors++; $display("FAIL full_count got bht %0d pht %0d want 5 5", bwa_q.size(), pwa_q.size());
    end else begin
      checks++; if ({bwa_q[0], bwa_q[1], bwa_q[2], bwa_q[3], bwa_q[4]} !== {10'd16, 10'd17, 10'd18, 10'd19, 10'd22}) begin
        errors++; $display("FAIL full_order got %0d %0d %0d %0d %0d want 16 17 18 19 22", bwa_q[0], bwa_q[1], bwa_q[2], bwa_q[3], bwa_q[4]);
      end
      checks++; if ({bwd_q[0], bwd_q[1], bwd_q[2], bwd_q[3], bwd_q[4]} !== {6'd1, 6'd0, 6'd1, 6'd1, 6'd0}) begin
        errors++; $display("FAIL full_hist got %h %h %h %h %h want 1 0 1 1 0", bwd_q[0], bwd_q[1], bwd_q[2], bwd_q[3], bwd_q[4]);
      end
      checks++; if ({pwd_q[0], pwd_q[1], pwd_q[2], pwd_q[3], pwd_q[4]} !== 10'b01_00_01_11_01) begin
        errors++; $display("FAIL full_ctr got %b want 0100011101", {pwd_q[0], pwd_q[1], pwd_q[2], pwd_q[3], pwd_q[4]});
      end
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL full_drain got %0d want 0", q_count); end
  endtask

  task automatic test_reset_mid();
    branchM = 1'b1; pcM = 32'h0000_0010; actual_takeM = 1'b1; tick();
    branchM = 1'b0; tick();
    branchM = 1'b1; pcM = 32'h0000_0014; tick();
    pcM = 32'h0000_0018; tick();
    rst = 1'b1; #1;
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL mid_q_pre got %0d want 2", q_count); end
    checks++; if (en_all !== 4'b0 || upd_drop !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b/%b want 0000/0", en_all, upd_drop); end
    tick();
    rst = 1'b0; #1;
    checks++; if (bht_port !== {2'b11, 10'd0, 6'd0}) begin errors++; $display("FAIL mid_sweep0 got %h want %h", bht_port, {2'b11, 10'd0, 6'd0}); end
    checks++; if (pht_port !== {2'b11, 6'd0, 2'b11}) begin errors++; $display("FAIL mid_pht0 got %h want %h", pht_port, {2'b11, 6'd0, 2'b11}); end
    checks++; if (q_count !== 3'd0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_state got %0d/%b want 0/0", q_count, init_done); end
    checks++; if (upd_drop !== 1'b1) begin errors++; $display("FAIL mid_drop got %b want 1", upd_drop); end
    tick();
    branchM = 1'b0; #1;
    checks++; if (bht_addr !== 10'd1 || q_count !== 3'd0) begin errors++; $display("FAIL mid_sweep1 got %0d/%0d want 1/0", bht_addr, q_count); end
    tick();
  endtask

  initial begin
    rst = 1'b1; branchM = 1'b0; actual_takeM = 1'b0; pcM = '0; lookup_req = 1'b0;
    bht_rdata = '0; pht_rdata = '0;
    for (int i = 0; i < 1024; i++) bht_mem[i] = 6'h2a;
    for (int i = 0; i < 64; i++) pht_mem[i] = 2'b01;
    tick();
    test_reset();
    test_init();
    test_single_update();
    test_nt_walk();
    test_lookup_stall();
    test_fifo_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
